booth_product_accumulator: RTL and testbench
============================================

Name: booth_product_accumulator

Overview:
Downstream stage of the combinational Booth multiplier. Consumes its signed 2N-bit products over a valid/ready handshake and accumulates LEN consecutive products into one dot-product result. Per-step signed saturation is applied. Each completed result is presented on a valid/ready output port. Sits between the multiplier datapath and the result consumer (register bank or output FIFO).

Parameters:
N, 4, operand width of the upstream multiplier; products are 2N bits, two's complement.
LEN, 4, number of products per accumulation frame; legal range 1 or more.
ACC_W, 2N+4, accumulator and result width; legal range 2N or more.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
prod_in  input  2N  signed product from the Booth multiplier.
prod_valid  input  1  prod_in is valid this cycle.
prod_ready  output  1  block accepts prod_in this cycle.
clear  input  1  synchronous frame abort.
acc_out  output  ACC_W  signed accumulated result of the frame.
ovf  output  1  the frame saturated at least once; qualified by acc_valid.
acc_valid  output  1  acc_out and ovf are valid.
acc_ready  input  1  consumer accepts the result.
count  output  clog2(LEN+1)  products accepted in the current frame.

Behaviour:
- Reset values (asynchronous on rst=1): state=ACCUM, accumulator=0, count=0, acc_out=0, ovf=0, acc_valid=0. prod_ready=1 after reset releases.
- States:
  - ACCUM: prod_ready=1, acc_valid=0.
  - HOLD: prod_ready=0, acc_valid=1.
- Accept: a product is accepted on a rising edge where prod_valid=1 and prod_ready=1. prod_in is sign-extended to ACC_W+1 bits and added to the sign-extended accumulator.
- Saturation:
  - If the ACC_W+1-bit sum exceeds the ACC_W signed range, it is clamped to the maximum (0111..1) or minimum (1000..0) value.
  - Any clamp sets the frame's sticky overflow bit.
  - Later additions continue from the clamped value.
- Frame completion: on the LEN-th accept, the final saturated sum loads into acc_out, ovf takes the sticky value (including this step), count returns to 0, and the state moves to HOLD.
  - acc_valid rises the cycle after the LEN-th accept, so latency is 1 cycle.
- HOLD:
  - acc_out, ovf and acc_valid stay stable until acc_valid=1 and acc_ready=1 on an edge.
  - prod_valid is ignored; no product is consumed.
- Handshake complete: on that edge, the accumulator and sticky bit clear, acc_valid falls, and the state returns to ACCUM.
  - prod_ready=1 on the next cycle, giving one bubble cycle per frame.
- Without acc_ready, acc_valid never drops.
- Idle: no accept occurs while prod_valid=0, and the accumulator holds.
- clear=1 (synchronous):
  - Has priority over accept and over the HOLD handshake.
  - Discards the partial frame or a pending result: accumulator=0, sticky=0, count=0, acc_valid=0, state=ACCUM.
  - A product presented in the same cycle is not accumulated. prod_ready is not gated by clear, so this product is counted as consumed and dropped.
- LEN=1: every accept moves directly to HOLD.
- Asserting rst mid-frame or in HOLD drops all state immediately.
- ACC_W equal to 2N: saturation is reachable on the second product.

Test Plan:
- Basic frame, N=4, LEN=4, ACC_W=12: products 8'h0F (15), 8'h40 (64), 8'hC8 (-56), 8'hFE (-2), one per cycle, acc_ready=1 -> acc_out=12'h015 (21), ovf=0, acc_valid high exactly 1 cycle after the 4th accept.
- Negative sum: four accepts of 8'hC8 -> acc_out=12'hF20 (-224), ovf=0.
- Saturation, ACC_W=8: four accepts of 8'h40 -> clamp at the 2nd add, acc_out=8'h7F, ovf=1. Separately, four accepts of 8'hC8 -> acc_out=8'h80, ovf=1.
- Backpressure: complete a frame, then hold acc_ready=0 for 3 cycles with prod_valid=1 -> prod_ready=0 and acc_out/ovf stable throughout. acc_ready=1 -> acc_valid drops, prod_ready=1 on the next cycle, and the next frame starts with count=0.
- Clear mid-frame: accept 8'h40 and 8'h40, then pulse clear with prod_valid=1 and prod_in=8'h40 -> count=0 and that product is dropped. Then accept four 8'h01 -> acc_out=12'h004.
- Async reset: assert rst between clock edges after 3 accepts -> all outputs zero immediately. A frame after release of four 8'h01 -> acc_out=12'h004.

Source files
------------

// File: rtl/booth_product_accumulator_if.sv
// Handshake bundle between the Booth multiplier, the product accumulator and the result consumer.
// The master side drives products and result acceptance; the slave side is the accumulator.
interface booth_product_accumulator_if #(
    parameter int N     = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = 2 * N + 4
);
    localparam int CNT_W = $clog2(LEN + 1);

    logic [2*N-1:0]   prod_in;
    logic             prod_valid;
    logic             prod_ready;
    logic             clear;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic             acc_valid;
    logic             acc_ready;
    logic [CNT_W-1:0] count;

    modport master (
        output prod_in, prod_valid, clear, acc_ready,
        input  prod_ready, acc_out, ovf, acc_valid, count
    );

    modport slave (
        input  prod_in, prod_valid, clear, acc_ready,
        output prod_ready, acc_out, ovf, acc_valid, count
    );
endinterface

// File: rtl/booth_product_accumulator.sv
// Accumulates LEN signed Booth products into one saturating dot-product result,
// then holds the result on a valid/ready port until the consumer takes it.
module booth_product_accumulator #(
    parameter int N     = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = 2 * N + 4
) (
    input  logic clk,
    input  logic rst,
    booth_product_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(LEN + 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic             sticky_q, sticky_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ACC_W-1:0] sat_sum_s;
    logic             clamp_s;
    logic             last_s;

    // Returns {clamped, saturated sum}; the extra top bit of the sum exposes signed overflow.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [2*N-1:0] p);
        logic [ACC_W:0] sum;
        logic [ACC_W:0] ret;
        sum = {a[ACC_W-1], a} + {{(ACC_W + 1 - 2 * N){p[2*N-1]}}, p};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W]) begin
                ret = {1'b1, 1'b1, {(ACC_W - 1){1'b0}}};
            end else begin
                ret = {1'b1, 1'b0, {(ACC_W - 1){1'b1}}};
            end
        end else begin
            ret = {1'b0, sum[ACC_W-1:0]};
        end
        return ret;
    endfunction

    assign {clamp_s, sat_sum_s} = sat_add(acc_q, bus.prod_in);
    assign last_s = (count_q == CNT_W'(LEN - 1));

    assign bus.prod_ready = (state_q == ST_ACCUM);
    assign bus.acc_valid  = (state_q == ST_HOLD);
    assign bus.acc_out    = acc_out_q;
    assign bus.ovf        = ovf_q;
    assign bus.count      = count_q;

    // Next-state logic: clear wins over both accepting a product and the result handshake.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        sticky_d  = sticky_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        if (bus.clear) begin
            state_d  = ST_ACCUM;
            acc_d    = {ACC_W{1'b0}};
            sticky_d = 1'b0;
            count_d  = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (bus.prod_valid) begin
                        acc_d    = sat_sum_s;
                        sticky_d = sticky_q | clamp_s;
                        if (last_s) begin
                            acc_out_d = sat_sum_s;
                            ovf_d     = sticky_q | clamp_s;
                            count_d   = {CNT_W{1'b0}};
                            state_d   = ST_HOLD;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        acc_d = acc_q;
                    end
                end
                ST_HOLD: begin
                    if (bus.acc_ready) begin
                        acc_d    = {ACC_W{1'b0}};
                        sticky_d = 1'b0;
                        state_d  = ST_ACCUM;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            acc_q     <= {ACC_W{1'b0}};
            acc_out_q <= {ACC_W{1'b0}};
            sticky_q  <= 1'b0;
            ovf_q     <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            sticky_q  <= sticky_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: directed frames on a 12-bit and an 8-bit accumulator,
// then random traffic on both against an integer frame model.
module tb_booth_product_accumulator;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    booth_product_accumulator_if #(.N(4), .LEN(4), .ACC_W(12)) bus12 ();
    booth_product_accumulator_if #(.N(4), .LEN(4), .ACC_W(8))  bus8 ();

    booth_product_accumulator #(.N(4), .LEN(4), .ACC_W(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));
    booth_product_accumulator #(.N(4), .LEN(4), .ACC_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push12(input logic [7:0] p);
        bus12.prod_valid = 1'b1;
        bus12.prod_in    = p;
        step();
    endtask

    task automatic push8(input logic [7:0] p);
        bus8.prod_valid = 1'b1;
        bus8.prod_in    = p;
        step();
    endtask

    task automatic idle_all();
        bus12.prod_valid = 1'b0; bus12.prod_in = 8'h00; bus12.clear = 1'b0; bus12.acc_ready = 1'b1;
        bus8.prod_valid  = 1'b0; bus8.prod_in  = 8'h00; bus8.clear  = 1'b0; bus8.acc_ready  = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        #12;
        n_checks++; if (bus12.acc_out !== 12'h000 || bus12.ovf !== 1'b0) $display("FAIL reset_out12: got %h/%b expected 000/0", bus12.acc_out, bus12.ovf); else n_pass++;
        n_checks++; if (bus12.acc_valid !== 1'b0 || bus12.count !== 3'd0) $display("FAIL reset_valid_count: got %b/%0d expected 0/0", bus12.acc_valid, bus12.count); else n_pass++;
        n_checks++; if (bus8.acc_out !== 8'h00 || bus8.acc_valid !== 1'b0) $display("FAIL reset_out8: got %h/%b expected 00/0", bus8.acc_out, bus8.acc_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++; if (bus12.prod_ready !== 1'b1) $display("FAIL reset_prod_ready: got %b expected 1", bus12.prod_ready); else n_pass++;
    endtask

    task automatic test_basic_frame();
        push12(8'h0F);
        push12(8'h40);
        push12(8'hC8);
        n_checks++; if (bus12.acc_valid !== 1'b0 || bus12.count !== 3'd3) $display("FAIL basic_early: got valid %b count %0d expected 0/3", bus12.acc_valid, bus12.count); else n_pass++;
        push12(8'hFE);
        bus12.prod_valid = 1'b0;
        n_checks++; if (bus12.acc_valid !== 1'b1 || bus12.prod_ready !== 1'b0) $display("FAIL basic_valid: got %b/%b expected 1/0", bus12.acc_valid, bus12.prod_ready); else n_pass++;
        n_checks++; if (bus12.acc_out !== 12'h015 || bus12.ovf !== 1'b0 || bus12.count !== 3'd0) $display("FAIL basic_out: got %h/%b/%0d expected 015/0/0", bus12.acc_out, bus12.ovf, bus12.count); else n_pass++;
        step();
        n_checks++; if (bus12.acc_valid !== 1'b0 || bus12.prod_ready !== 1'b1) $display("FAIL basic_release: got %b/%b expected 0/1", bus12.acc_valid, bus12.prod_ready); else n_pass++;
    endtask

    task automatic test_negative();
        for (int i = 0; i < 4; i++) push12(8'hC8);
        bus12.prod_valid = 1'b0;
        n_checks++; if (bus12.acc_out !== 12'hF20 || bus12.ovf !== 1'b0 || bus12.acc_valid !== 1'b1) $display("FAIL negative_out: got %h/%b/%b expected F20/0/1", bus12.acc_out, bus12.ovf, bus12.acc_valid); else n_pass++;
        step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) push8(8'h40);
        bus8.prod_valid = 1'b0;
        n_checks++; if (bus8.acc_out !== 8'h7F || bus8.ovf !== 1'b1 || bus8.acc_valid !== 1'b1) $display("FAIL sat_pos: got %h/%b/%b expected 7F/1/1", bus8.acc_out, bus8.ovf, bus8.acc_valid); else n_pass++;
        step();
        for (int i = 0; i < 4; i++) push8(8'hC8);
        bus8.prod_valid = 1'b0;
        n_checks++; if (bus8.acc_out !== 8'h80 || bus8.ovf !== 1'b1) $display("FAIL sat_neg: got %h/%b expected 80/1", bus8.acc_out, bus8.ovf); else n_pass++;
        step();
        for (int i = 0; i < 4; i++) push8(8'h01);
        bus8.prod_valid = 1'b0;
        n_checks++; if (bus8.acc_out !== 8'h04 || bus8.ovf !== 1'b0) $display("FAIL sat_sticky_cleared: got %h/%b expected 04/0", bus8.acc_out, bus8.ovf); else n_pass++;
        step();
    endtask

    task automatic test_backpressure();
        bus12.acc_ready = 1'b0;
        push12(8'h01); push12(8'h02); push12(8'h03); push12(8'h04);
        bus12.prod_in = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus12.prod_ready !== 1'b0 || bus12.acc_valid !== 1'b1 || bus12.acc_out !== 12'h00A || bus12.ovf !== 1'b0)
                $display("FAIL bp_hold%0d: got rdy %b vld %b out %h ovf %b expected 0/1/00A/0", i, bus12.prod_ready, bus12.acc_valid, bus12.acc_out, bus12.ovf);
            else n_pass++;
            step();
        end
        bus12.acc_ready = 1'b1;
        step();
        bus12.prod_valid = 1'b0;
        n_checks++; if (bus12.acc_valid !== 1'b0 || bus12.prod_ready !== 1'b1 || bus12.count !== 3'd0) $display("FAIL bp_release: got %b/%b/%0d expected 0/1/0", bus12.acc_valid, bus12.prod_ready, bus12.count); else n_pass++;
    endtask

    task automatic test_clear();
        push12(8'h40);
        push12(8'h40);
        n_checks++; if (bus12.count !== 3'd2) $display("FAIL clear_pre_count: got %0d expected 2", bus12.count); else n_pass++;
        bus12.clear = 1'b1;
        push12(8'h40);
        bus12.clear = 1'b0;
        bus12.prod_valid = 1'b0;
        n_checks++; if (bus12.count !== 3'd0 || bus12.acc_valid !== 1'b0) $display("FAIL clear_count: got %0d/%b expected 0/0", bus12.count, bus12.acc_valid); else n_pass++;
        for (int i = 0; i < 4; i++) push12(8'h01);
        bus12.prod_valid = 1'b0;
        n_checks++; if (bus12.acc_out !== 12'h004 || bus12.acc_valid !== 1'b1) $display("FAIL clear_next_frame: got %h/%b expected 004/1", bus12.acc_out, bus12.acc_valid); else n_pass++;
        step();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) push12(8'h01);
        bus12.prod_valid = 1'b0;
        n_checks++; if (bus12.count !== 3'd3) $display("FAIL areset_pre_count: got %0d expected 3", bus12.count); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus12.count !== 3'd0 || bus12.acc_out !== 12'h000 || bus12.acc_valid !== 1'b0 || bus12.ovf !== 1'b0)
            $display("FAIL areset_now12: got %0d/%h/%b/%b expected 0/000/0/0", bus12.count, bus12.acc_out, bus12.acc_valid, bus12.ovf);
        else n_pass++;
        n_checks++; if (bus8.acc_out !== 8'h00) $display("FAIL areset_now8: got %h expected 00", bus8.acc_out); else n_pass++;
        #2 rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) push12(8'h01);
        bus12.prod_valid = 1'b0;
        n_checks++; if (bus12.acc_out !== 12'h004 || bus12.acc_valid !== 1'b1) $display("FAIL areset_frame: got %h/%b expected 004/1", bus12.acc_out, bus12.acc_valid); else n_pass++;
        step();
    endtask

    task automatic test_random();
        int m_acc[2], m_sticky[2], m_cnt[2], m_hold[2], m_out[2], m_ovf[2];
        int hi[2], lo[2];
        int obs_out, s, p;
        logic        v, r, c;
        logic [7:0]  pb;
        logic signed [7:0] ps;
        hi[0] = 2047; lo[0] = -2048;
        hi[1] = 127;  lo[1] = -128;
        // Synchronise both DUTs with the empty model state.
        bus12.clear = 1'b1; bus8.clear = 1'b1;
        step();
        for (int b = 0; b < 2; b++) begin
            m_acc[b] = 0; m_sticky[b] = 0; m_cnt[b] = 0; m_hold[b] = 0; m_out[b] = 0; m_ovf[b] = 0;
        end
        for (int it = 0; it < 400; it++) begin
            v  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 1) == 1);
            c  = ($urandom_range(0, 31) == 0);
            pb = 8'($urandom_range(0, 255));
            ps = pb;
            p  = ps;
            bus12.prod_valid = v; bus12.prod_in = pb; bus12.acc_ready = r; bus12.clear = c;
            bus8.prod_valid  = v; bus8.prod_in  = pb; bus8.acc_ready  = r; bus8.clear  = c;
            for (int b = 0; b < 2; b++) begin
                if (c) begin
                    m_acc[b] = 0; m_sticky[b] = 0; m_cnt[b] = 0; m_hold[b] = 0;
                end else if (m_hold[b] != 0) begin
                    if (r) begin
                        m_hold[b] = 0; m_acc[b] = 0; m_sticky[b] = 0;
                    end
                end else if (v) begin
                    s = m_acc[b] + p;
                    if (s > hi[b]) begin s = hi[b]; m_sticky[b] = 1; end
                    else if (s < lo[b]) begin s = lo[b]; m_sticky[b] = 1; end
                    m_acc[b] = s;
                    m_cnt[b] = m_cnt[b] + 1;
                    if (m_cnt[b] == 4) begin
                        m_cnt[b] = 0; m_hold[b] = 1; m_out[b] = s; m_ovf[b] = m_sticky[b];
                    end
                end
            end
            step();
            for (int b = 0; b < 2; b++) begin
                if (b == 0) obs_out = int'($signed(bus12.acc_out));
                else        obs_out = int'($signed(bus8.acc_out));
                n_checks++;
                if ((b == 0 ? bus12.acc_valid : bus8.acc_valid) !== (m_hold[b] != 0) ||
                    (b == 0 ? bus12.prod_ready : bus8.prod_ready) !== (m_hold[b] == 0) ||
                    int'(b == 0 ? bus12.count : bus8.count) != m_cnt[b])
                    $display("FAIL rand_ctl bus%0d it%0d: got vld %b cnt %0d expected vld %0d cnt %0d", b, it,
                             (b == 0 ? bus12.acc_valid : bus8.acc_valid), (b == 0 ? bus12.count : bus8.count), m_hold[b], m_cnt[b]);
                else n_pass++;
                if (m_hold[b] != 0) begin
                    n_checks++;
                    if (obs_out != m_out[b] || (b == 0 ? bus12.ovf : bus8.ovf) !== (m_ovf[b] != 0))
                        $display("FAIL rand_out bus%0d it%0d: got %0d ovf %b expected %0d ovf %0d", b, it, obs_out,
                                 (b == 0 ? bus12.ovf : bus8.ovf), m_out[b], m_ovf[b]);
                    else n_pass++;
                end
            end
        end
        idle_all();
        step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        test_reset();
        test_basic_frame();
        test_negative();
        test_saturation();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
